// File: rtl/wordlist_ctrl_pkg.sv
// Shared widths, FSM state encoding and counter helpers for the wordlist
// sequencer/arbiter.
package wordlist_ctrl_pkg;

  localparam int unsigned WORD_W      = 25;
  localparam int unsigned LETTER_W    = 5;
  localparam int unsigned PICKNUM_W   = 12;
  localparam int unsigned TCNT_W      = 5;
  localparam int unsigned SCNT_W      = 2;
  localparam int unsigned TIMEOUT_DEF = 31;
  localparam int unsigned SETTLE_DEF  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SEARCH = 3'd2,
    PWAIT  = 3'd3,
    PCAP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Timeout counter increment that sticks at the limit instead of wrapping.
  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v,
                                                input logic [TCNT_W-1:0] lim);
    return (v >= lim) ? lim : v + TCNT_W'(1);
  endfunction

endpackage

// File: rtl/wordlist_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; index 0 is the guess checker, index 1
// the target picker. The pointer names the side favoured on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
      else                gnt_o = req_i;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0])      ptr_d = 1'b1;
    else if (gnt_o[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wordlist_ctrl.sv
// Sequencer/arbiter sharing the wordlist port between the guess checker and
// the target picker; masks stale ready, aligns picked data, adds a timeout.
module wordlist_ctrl
  import wordlist_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_DEF,
  parameter int unsigned TIMEOUT       = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 chk_req,
  input  logic [WORD_W-1:0]    chk_word,
  output logic                 chk_done,
  output logic                 chk_valid,
  output logic                 chk_err,
  input  logic                 pick_req,
  output logic                 pick_done,
  output logic [WORD_W-1:0]    pick_word,
  output logic [PICKNUM_W-1:0] pick_num,
  output logic                 pick_err,
  output logic [WORD_W-1:0]    wl_question,
  input  logic                 wl_ready,
  input  logic                 wl_valid,
  input  logic [WORD_W-1:0]    wl_picked,
  input  logic [PICKNUM_W-1:0] wl_picked_num,
  output logic                 busy
);

  localparam logic [TCNT_W-1:0] TOUT_LIM   = TCNT_W'(TIMEOUT);
  localparam logic [SCNT_W-1:0] SETTLE_LD  = SCNT_W'(SETTLE_CYCLES);

  state_t                 state_q, state_d;
  logic [SCNT_W-1:0]      settle_q, settle_d;
  logic [TCNT_W-1:0]      tout_q, tout_d, tout_inc;
  logic [WORD_W-1:0]      question_q, question_d;
  logic                   chk_done_q, chk_done_d;
  logic                   chk_valid_q, chk_valid_d;
  logic                   chk_err_q, chk_err_d;
  logic                   pick_done_q, pick_done_d;
  logic                   pick_err_q, pick_err_d;
  logic [WORD_W-1:0]      pick_word_q, pick_word_d;
  logic [PICKNUM_W-1:0]   pick_num_q, pick_num_d;
  logic                   arb_en;
  logic [1:0]             gnt;

  assign arb_en   = (state_q == IDLE);
  assign tout_inc = sat_inc(tout_q, TOUT_LIM);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (arb_en),
    .req_i ({pick_req, chk_req}),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    tout_d      = tout_q;
    question_d  = question_q;
    chk_done_d  = 1'b0;
    chk_valid_d = chk_valid_q;
    chk_err_d   = chk_err_q;
    pick_done_d = 1'b0;
    pick_err_d  = pick_err_q;
    pick_word_d = pick_word_q;
    pick_num_d  = pick_num_q;

    case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          question_d = chk_word;
          settle_d   = SETTLE_LD;
          state_d    = SETTLE;
        end else if (gnt[1]) begin
          tout_d  = '0;
          state_d = PWAIT;
        end
      end

      // Leave on the cycle the counter would hit zero, so SETTLE lasts
      // exactly SETTLE_CYCLES cycles and the first SEARCH sample is fresh.
      SETTLE: begin
        if (settle_q <= SCNT_W'(1)) begin
          settle_d = '0;
          tout_d   = '0;
          state_d  = SEARCH;
        end else begin
          settle_d = settle_q - SCNT_W'(1);
        end
      end

      SEARCH: begin
        if (wl_ready) begin
          chk_valid_d = wl_valid;
          chk_err_d   = 1'b0;
          chk_done_d  = 1'b1;
          state_d     = DONE;
        end else if (tout_inc == TOUT_LIM) begin
          chk_valid_d = 1'b0;
          chk_err_d   = 1'b1;
          chk_done_d  = 1'b1;
          state_d     = DONE;
        end else begin
          tout_d = tout_inc;
        end
      end

      PWAIT: begin
        if (wl_ready) begin
          state_d = PCAP;
        end else if (tout_inc == TOUT_LIM) begin
          pick_err_d  = 1'b1;
          pick_done_d = 1'b1;
          state_d     = DONE;
        end else begin
          tout_d = tout_inc;
        end
      end

      // wl_picked lags wl_ready by one cycle.
      PCAP: begin
        pick_word_d = wl_picked;
        pick_num_d  = wl_picked_num;
        pick_err_d  = 1'b0;
        pick_done_d = 1'b1;
        state_d     = DONE;
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      tout_q      <= '0;
      question_q  <= '0;
      chk_done_q  <= 1'b0;
      chk_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
      pick_done_q <= 1'b0;
      pick_err_q  <= 1'b0;
      pick_word_q <= '0;
      pick_num_q  <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      tout_q      <= tout_d;
      question_q  <= question_d;
      chk_done_q  <= chk_done_d;
      chk_valid_q <= chk_valid_d;
      chk_err_q   <= chk_err_d;
      pick_done_q <= pick_done_d;
      pick_err_q  <= pick_err_d;
      pick_word_q <= pick_word_d;
      pick_num_q  <= pick_num_d;
    end
  end

  assign chk_done    = chk_done_q;
  assign chk_valid   = chk_valid_q;
  assign chk_err     = chk_err_q;
  assign pick_done   = pick_done_q;
  assign pick_err    = pick_err_q;
  assign pick_word   = pick_word_q;
  assign pick_num    = pick_num_q;
  assign wl_question = question_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_wordlist_ctrl.sv
// Directed bench for wordlist_ctrl: drives the wordlist stub cycle by cycle
// and checks result timing and values against hand-derived expectations.
module tb_wordlist_ctrl;

  logic        clk;
  logic        rst_n;
  logic        chk_req;
  logic [24:0] chk_word;
  logic        chk_done, chk_valid, chk_err;
  logic        pick_req;
  logic        pick_done;
  logic [24:0] pick_word;
  logic [11:0] pick_num;
  logic        pick_err;
  logic [24:0] wl_question;
  logic        wl_ready, wl_valid;
  logic [24:0] wl_picked;
  logic [11:0] wl_picked_num;
  logic        busy;

  int vectors;
  int miscompares;

  localparam logic [24:0] JUNK_WORD = 25'h0AAAAAA;
  localparam logic [11:0] JUNK_NUM  = 12'hABC;

  wordlist_ctrl #(.SETTLE_CYCLES(2), .TIMEOUT(31)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .chk_req       (chk_req),
    .chk_word      (chk_word),
    .chk_done      (chk_done),
    .chk_valid     (chk_valid),
    .chk_err       (chk_err),
    .pick_req      (pick_req),
    .pick_done     (pick_done),
    .pick_word     (pick_word),
    .pick_num      (pick_num),
    .pick_err      (pick_err),
    .wl_question   (wl_question),
    .wl_ready      (wl_ready),
    .wl_valid      (wl_valid),
    .wl_picked     (wl_picked),
    .wl_picked_num (wl_picked_num),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the cycle in which the request is raised; the stub inputs for
  // cycle k are set right after edge k. Returns the cycle chk_done was seen.
  task automatic do_chk(input logic [24:0] w, input int rdy_at, input logic vld,
                        input logic stale, input logic scramble,
                        output int dcyc, output logic v, output logic e,
                        output logic [24:0] q);
    dcyc = -1; v = 1'b0; e = 1'b0; q = '0;
    chk_req  = 1'b1;
    chk_word = w;
    wl_ready = (stale) || (rdy_at == 0);
    wl_valid = stale ? 1'b1 : vld;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (chk_done) begin
        dcyc = k; v = chk_valid; e = chk_err; q = wl_question;
        break;
      end
      if (scramble && k == 5) chk_word = ~w;
      wl_ready = (stale && k <= 1) || (rdy_at >= 0 && k >= rdy_at);
      wl_valid = (stale && k <= 1) ? 1'b1 : vld;
    end
    chk_req  = 1'b0;
    wl_ready = 1'b0;
    wl_valid = 1'b0;
    tick();
  endtask

  task automatic do_pick(input int rdy_at, input logic [24:0] w, input logic [11:0] n,
                         output int dcyc, output logic [24:0] pw, output logic [11:0] pn,
                         output logic pe, output logic [24:0] q);
    dcyc = -1; pw = '0; pn = '0; pe = 1'b0; q = '0;
    pick_req      = 1'b1;
    wl_ready      = (rdy_at == 0);
    wl_picked     = JUNK_WORD;
    wl_picked_num = JUNK_NUM;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (pick_done) begin
        dcyc = k; pw = pick_word; pn = pick_num; pe = pick_err; q = wl_question;
        break;
      end
      wl_ready      = (k == rdy_at);
      wl_picked     = (rdy_at >= 0 && k > rdy_at) ? w : JUNK_WORD;
      wl_picked_num = (rdy_at >= 0 && k > rdy_at) ? n : JUNK_NUM;
    end
    pick_req = 1'b0;
    wl_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    chk_req = 1'b0; pick_req = 1'b0; chk_word = '0;
    wl_ready = 1'b0; wl_valid = 1'b0; wl_picked = JUNK_WORD; wl_picked_num = JUNK_NUM;
    tick(); tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
    vectors++;
    if (wl_question !== 25'h0) begin miscompares++; $display("FAIL reset_question got=%h want=0", wl_question); end
    vectors++;
    if ({pick_word, pick_num} !== 37'h0) begin
      miscompares++; $display("FAIL reset_pick got=%h/%0d want=0/0", pick_word, pick_num);
    end
    vectors++;
    if ({chk_done, chk_valid, chk_err, pick_done, pick_err} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags got=%b want=00000",
                              {chk_done, chk_valid, chk_err, pick_done, pick_err});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_min_latency();
    int d; logic v, e; logic [24:0] q;
    do_chk(25'h0123456, 0, 1'b1, 1'b0, 1'b0, d, v, e, q);
    vectors++;
    if (d !== 4) begin miscompares++; $display("FAIL min_latency got=%0d want=4", d); end
    vectors++;
    if ({v, e} !== 2'b10) begin miscompares++; $display("FAIL min_result got=%b want=10", {v, e}); end
    // Same word again still pays the settle cycles.
    do_chk(25'h0123456, 0, 1'b1, 1'b0, 1'b0, d, v, e, q);
    vectors++;
    if (d !== 4) begin miscompares++; $display("FAIL same_word_latency got=%0d want=4", d); end
  endtask

  task automatic test_check_hit();
    int d; logic v, e; logic [24:0] q;
    do_chk(25'h0421084, 17, 1'b1, 1'b0, 1'b1, d, v, e, q);
    vectors++;
    if (d !== 18) begin miscompares++; $display("FAIL hit_latency got=%0d want=18", d); end
    vectors++;
    if ({v, e} !== 2'b10) begin miscompares++; $display("FAIL hit_result got=%b want=10", {v, e}); end
    vectors++;
    if (q !== 25'h0421084) begin miscompares++; $display("FAIL hit_question got=%h want=0421084", q); end
  endtask

  task automatic test_stale_ready();
    int d; logic v, e; logic [24:0] q;
    do_chk(25'h1FFFFFF, 6, 1'b0, 1'b1, 1'b0, d, v, e, q);
    vectors++;
    if (d !== 7) begin miscompares++; $display("FAIL stale_latency got=%0d want=7", d); end
    vectors++;
    if ({v, e} !== 2'b00) begin miscompares++; $display("FAIL stale_result got=%b want=00", {v, e}); end
  endtask

  task automatic test_pick();
    int d; logic [24:0] pw, q; logic [11:0] pn; logic pe;
    do_pick(5, 25'h1A2B3C4, 12'd417, d, pw, pn, pe, q);
    vectors++;
    if (d !== 7) begin miscompares++; $display("FAIL pick_latency got=%0d want=7", d); end
    vectors++;
    if (pw !== 25'h1A2B3C4) begin miscompares++; $display("FAIL pick_word got=%h want=1A2B3C4", pw); end
    vectors++;
    if (pn !== 12'd417 || pe !== 1'b0) begin
      miscompares++; $display("FAIL pick_num_err got=%0d/%b want=417/0", pn, pe);
    end
    vectors++;
    if (q !== 25'h1FFFFFF) begin miscompares++; $display("FAIL pick_question got=%h want=1FFFFFF", q); end
  endtask

  task automatic test_timeout();
    int d; logic v, e; logic [24:0] q, pw; logic [11:0] pn; logic pe;
    do_chk(25'h0ABCDEF, -1, 1'b1, 1'b0, 1'b0, d, v, e, q);
    vectors++;
    if (d !== 34) begin miscompares++; $display("FAIL chk_timeout_cycle got=%0d want=34", d); end
    vectors++;
    if ({v, e} !== 2'b01) begin miscompares++; $display("FAIL chk_timeout_flags got=%b want=01", {v, e}); end
    do_pick(-1, 25'h0, 12'd0, d, pw, pn, pe, q);
    vectors++;
    if (d !== 32) begin miscompares++; $display("FAIL pick_timeout_cycle got=%0d want=32", d); end
    vectors++;
    if (pe !== 1'b1) begin miscompares++; $display("FAIL pick_timeout_err got=%b want=1", pe); end
    vectors++;
    if (pw !== 25'h1A2B3C4 || pn !== 12'd417) begin
      miscompares++; $display("FAIL pick_timeout_hold got=%h/%0d want=1A2B3C4/417", pw, pn);
    end
  endtask

  task automatic test_back_to_back();
    int order[4];
    int n;
    int both;
    n = 0; both = 0;
    rst_n = 1'b0;
    chk_req = 1'b1; pick_req = 1'b1; chk_word = 25'h0842108;
    wl_ready = 1'b1; wl_valid = 1'b1; wl_picked = 25'h0135579; wl_picked_num = 12'd9;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 200 && n < 4; k++) begin
      tick();
      if (chk_done && pick_done) both++;
      if (chk_done) begin order[n] = 0; n++; chk_req = 1'b0; end
      else chk_req = 1'b1;
      if (pick_done && n < 4) begin order[n] = 1; n++; pick_req = 1'b0; end
      else pick_req = 1'b1;
    end
    chk_req = 1'b0; pick_req = 1'b0; wl_ready = 1'b0; wl_valid = 1'b0;
    tick(); tick();
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL rr_count got=%0d want=4", n); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i < n && order[i] !== (i % 2)) begin
        miscompares++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, order[i], i % 2);
      end
    end
    vectors++;
    if (both !== 0) begin miscompares++; $display("FAIL rr_dual_pulse got=%0d want=0", both); end
  endtask

  task automatic test_reset_mid();
    int d; int seen; logic v, e; logic [24:0] q;
    seen = 0;
    chk_req = 1'b1; chk_word = 25'h0777777; wl_ready = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b want=0", busy); end
    vectors++;
    if (wl_question !== 25'h0) begin miscompares++; $display("FAIL midrst_question got=%h want=0", wl_question); end
    chk_req = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); if (chk_done) seen++; end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(); if (chk_done) seen++; end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL midrst_done got=%0d want=0", seen); end
    do_chk(25'h0777777, 5, 1'b1, 1'b0, 1'b0, d, v, e, q);
    vectors++;
    if (d !== 6 || {v, e} !== 2'b10) begin
      miscompares++; $display("FAIL midrst_after got=%0d/%b want=6/10", d, {v, e});
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_min_latency();
    test_check_hit();
    test_stale_ready();
    test_pick();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
